// File: rtl/mux_8_32bit.sv
// mux_8_32bit: registered 8-to-1 word multiplexer for the ALU output stage.
// ch picks one of in0..in7. The chosen word is loaded into out on a rising clk
// edge when en is high. rst_n clears out asynchronously.
module mux_8_32bit #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3   // fixed: eight inputs need exactly three select bits
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] ch,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] sel_next;
  logic [WIDTH-1:0] out_reg;

  // Selection: every 3-bit code maps to an input, so no default branch is needed
  // and an unselected input never reaches the register.
  always_comb begin
    sel_next = in0;
    case (ch)
      3'd0: sel_next = in0;
      3'd1: sel_next = in1;
      3'd2: sel_next = in2;
      3'd3: sel_next = in3;
      3'd4: sel_next = in4;
      3'd5: sel_next = in5;
      3'd6: sel_next = in6;
      3'd7: sel_next = in7;
    endcase
  end

  // Output register: clears at once on reset, loads the selected word when enabled,
  // and otherwise holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= '0;
    end else if (en) begin
      out_reg <= sel_next;
    end
  end

  assign out = out_reg;

endmodule

// File: tb/tb_mux_8_32bit.sv
// tb_mux_8_32bit: directed scenarios plus a randomized run.
// The randomized run is checked against an array-indexed reference model.
module tb_mux_8_32bit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [2:0]  ch;
  logic [31:0] din [8];
  logic [31:0] out;

  int checks;
  int errors;

  mux_8_32bit #(.WIDTH(32), .SEL_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .ch   (ch),
    .in0  (din[0]),
    .in1  (din[1]),
    .in2  (din[2]),
    .in3  (din[3]),
    .in4  (din[4]),
    .in5  (din[5]),
    .in6  (din[6]),
    .in7  (din[7]),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_defaults();
    for (int i = 0; i < 8; i++) din[i] = 32'(i + 1);
  endtask

  task automatic test_reset();
    load_defaults();
    en    = 1'b1;
    ch    = 3'd3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 32'd0) begin
      errors++;
      $display("FAIL reset_immediate out=%h expected=%h", out, 32'd0);
    end else $display("ok reset_immediate out=%h", out);
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (out !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold out=%h expected=%h", out, 32'd0);
      end else $display("ok reset_hold edge=%0d out=%h", k, out);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (out !== 32'd4) begin
      errors++;
      $display("FAIL reset_release out=%h expected=%h", out, 32'd4);
    end else $display("ok reset_release out=%h", out);
  endtask

  task automatic test_sweep();
    logic [31:0] prev;
    for (int i = 0; i < 8; i++) begin
      prev = out;
      ch   = 3'(i);
      #1;
      checks++;
      if (out !== prev) begin
        errors++;
        $display("FAIL sweep_latency ch=%0d out=%h expected=%h", i, out, prev);
      end
      step();
      checks++;
      if (out !== 32'(i + 1)) begin
        errors++;
        $display("FAIL sweep ch=%0d out=%h expected=%h", i, out, 32'(i + 1));
      end else $display("ok sweep ch=%0d out=%h", i, out);
    end
  endtask

  task automatic test_truncation();
    int sel_val;
    sel_val = 8;
    ch = 3'(sel_val);
    step();
    checks++;
    if (out !== 32'd1) begin
      errors++;
      $display("FAIL truncation out=%h expected=%h", out, 32'd1);
    end else $display("ok truncation sel=%0d out=%h", sel_val, out);
  endtask

  task automatic test_hold();
    ch = 3'd5;
    en = 1'b1;
    step();
    checks++;
    if (out !== 32'd6) begin
      errors++;
      $display("FAIL hold_load out=%h expected=%h", out, 32'd6);
    end else $display("ok hold_load out=%h", out);
    en = 1'b0;
    ch = 3'd2;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (out !== 32'd6) begin
        errors++;
        $display("FAIL hold_keep out=%h expected=%h", out, 32'd6);
      end else $display("ok hold_keep edge=%0d out=%h", k, out);
    end
    en = 1'b1;
    step();
    checks++;
    if (out !== 32'd3) begin
      errors++;
      $display("FAIL hold_resume out=%h expected=%h", out, 32'd3);
    end else $display("ok hold_resume out=%h", out);
  endtask

  task automatic test_full_width();
    din[7] = 32'hFFFF_FFFF;
    din[6] = 32'h8000_0001;
    ch = 3'd7;
    step();
    checks++;
    if (out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL width_all_ones out=%h expected=%h", out, 32'hFFFF_FFFF);
    end else $display("ok width_all_ones out=%h", out);
    ch = 3'd6;
    step();
    checks++;
    if (out !== 32'h8000_0001) begin
      errors++;
      $display("FAIL width_msb_lsb out=%h expected=%h", out, 32'h8000_0001);
    end else $display("ok width_msb_lsb out=%h", out);
    load_defaults();
  endtask

  task automatic test_async_reset();
    ch = 3'd4;
    step();
    checks++;
    if (out !== 32'd5) begin
      errors++;
      $display("FAIL async_pre out=%h expected=%h", out, 32'd5);
    end else $display("ok async_pre out=%h", out);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 32'd0) begin
      errors++;
      $display("FAIL async_clear out=%h expected=%h", out, 32'd0);
    end else $display("ok async_clear out=%h", out);
    step();
    checks++;
    if (out !== 32'd0) begin
      errors++;
      $display("FAIL async_held out=%h expected=%h", out, 32'd0);
    end else $display("ok async_held out=%h", out);
    rst_n = 1'b1;
    step();
    checks++;
    if (out !== 32'd5) begin
      errors++;
      $display("FAIL async_reload out=%h expected=%h", out, 32'd5);
    end else $display("ok async_reload out=%h", out);
  endtask

  // Randomized: inputs, select, and enable change every cycle, with occasional
  // reset pulses. The model keeps the last captured word and indexes the input
  // array with the select value taken modulo eight.
  task automatic test_random();
    logic [31:0] model;
    int          sel_val;
    model = out;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 8; i++) din[i] = $urandom;
      sel_val = int'($urandom_range(0, 15));
      ch      = 3'(sel_val);
      en      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        model = 32'd0;
        #1;
        checks++;
        if (out !== model) begin
          errors++;
          $display("FAIL rand_reset n=%0d out=%h expected=%h", n, out, model);
        end else $display("ok rand_reset n=%0d out=%h", n, out);
        rst_n = 1'b1;
      end
      if (en) model = din[sel_val % 8];
      step();
      checks++;
      if (out !== model) begin
        errors++;
        $display("FAIL rand n=%0d sel=%0d en=%0b out=%h expected=%h",
                 n, sel_val, en, out, model);
      end else $display("ok rand n=%0d sel=%0d en=%0b out=%h", n, sel_val, en, out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    ch     = 3'd0;
    load_defaults();
    test_reset();
    test_sweep();
    test_truncation();
    test_hold();
    test_full_width();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
